// File: rtl/shifter_pkg.sv
// rtl/shifter_pkg.sv - op codes, fill modes, stage control payload and level-to-stage split helpers
package shifter_pkg;

  typedef enum logic [2:0] {
    OP_SLL = 3'b000,
    OP_SRL = 3'b001,
    OP_SRA = 3'b010,
    OP_ROL = 3'b011,
    OP_ROR = 3'b100
  } shift_op_e;

  typedef enum logic [1:0] {
    FILL_ZERO = 2'd0,
    FILL_SIGN = 2'd1,
    FILL_WRAP = 2'd2
  } fill_mode_e;

  // Op decoded once at the input; later stages only need direction and fill.
  typedef struct packed {
    logic       right;
    fill_mode_e mode;
    logic       fill;
    logic       illegal;
  } stage_ctrl_t;

  function automatic int shamt_w(input int xlen);
    return $clog2(xlen);
  endfunction

  // First barrel level owned by stage s; earlier stages absorb the remainder.
  function automatic int level_first(input int nlev, input int stages, input int s);
    int base;
    int extra;
    base  = nlev / stages;
    extra = nlev % stages;
    return s * base + ((s < extra) ? s : extra);
  endfunction

  function automatic int level_stage(input int nlev, input int stages, input int k);
    int stg;
    stg = 0;
    for (int s = 0; s < stages; s++) begin
      if (k >= level_first(nlev, stages, s)) stg = s;
    end
    return stg;
  endfunction

endpackage

// File: rtl/shift_level.sv
// rtl/shift_level.sv - one barrel level shifting by AMOUNT; wrap fill only with SHIFTER_ROTATE_EN
module shift_level
  import shifter_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int AMOUNT = 1
) (
  input  logic            [XLEN-1:0] i_data,
  input  logic                       i_en,
  input  logic                       i_right,
  input  fill_mode_e                 i_mode,
  input  logic                       i_fill,
  output logic            [XLEN-1:0] o_data
);

  logic [AMOUNT-1:0] w_fill_vec;

  // Pick the bits shifted in, then shift by AMOUNT when enabled.
  always_comb begin
    w_fill_vec = {AMOUNT{(i_mode == FILL_SIGN) & i_fill}};
`ifdef SHIFTER_ROTATE_EN
    if (i_mode == FILL_WRAP) begin
      w_fill_vec = i_right ? i_data[AMOUNT-1:0] : i_data[XLEN-1 -: AMOUNT];
    end
`endif
    if (!i_en) begin
      o_data = i_data;
    end else if (i_right) begin
      o_data = {w_fill_vec, i_data[XLEN-1:AMOUNT]};
    end else begin
      o_data = {i_data[XLEN-AMOUNT-1:0], w_fill_vec};
    end
  end

endmodule

// File: rtl/pipelined_shifter.sv
// rtl/pipelined_shifter.sv - pipelined barrel shifter with valid/ready, tag and flush; rotates with SHIFTER_ROTATE_EN
module pipelined_shifter
  import shifter_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int PIPE_STAGES = 2,
  parameter int TAG_W       = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [XLEN-1:0]  in_a,
  input  logic [XLEN-1:0]  in_b,
  input  logic [2:0]       in_op,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_res,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_illegal
);

  localparam int SHAMT_W = shamt_w(XLEN);

  typedef struct packed {
    logic [XLEN-1:0]    data;
    logic [SHAMT_W-1:0] shamt;
    stage_ctrl_t        ctrl;
    logic [TAG_W-1:0]   tag;
  } payload_t;

  payload_t               w_in_payload;
  payload_t               w_stage_in   [PIPE_STAGES];
  logic     [XLEN-1:0]    w_stage_data [PIPE_STAGES];
  logic     [XLEN-1:0]    w_lvl_out    [SHAMT_W];
  payload_t               r_pipe       [PIPE_STAGES];
  logic [PIPE_STAGES-1:0] r_valid;
  logic                   w_advance;
  logic                   w_unused_ok;

  assign out_valid   = r_valid[PIPE_STAGES-1];
  assign w_advance   = !out_valid || out_ready;
  assign in_ready    = w_advance;
  assign out_res     = r_pipe[PIPE_STAGES-1].data;
  assign out_tag     = r_pipe[PIPE_STAGES-1].tag;
  assign out_illegal = r_pipe[PIPE_STAGES-1].ctrl.illegal;

  // Decode the op into direction/fill; illegal ops enter with zero data so they leave as zero.
  always_comb begin
    w_in_payload              = '0;
    w_in_payload.shamt        = in_b[SHAMT_W-1:0];
    w_in_payload.tag          = in_tag;
    w_in_payload.ctrl.fill    = in_a[XLEN-1];
    w_in_payload.ctrl.mode    = FILL_ZERO;
    w_in_payload.ctrl.right   = 1'b0;
    w_in_payload.ctrl.illegal = 1'b0;
    case (in_op)
      OP_SLL: w_in_payload.ctrl.right = 1'b0;
      OP_SRL: w_in_payload.ctrl.right = 1'b1;
      OP_SRA: begin
        w_in_payload.ctrl.right = 1'b1;
        w_in_payload.ctrl.mode  = FILL_SIGN;
      end
`ifdef SHIFTER_ROTATE_EN
      OP_ROL: w_in_payload.ctrl.mode = FILL_WRAP;
      OP_ROR: begin
        w_in_payload.ctrl.right = 1'b1;
        w_in_payload.ctrl.mode  = FILL_WRAP;
      end
`endif
      default: w_in_payload.ctrl.illegal = 1'b1;
    endcase
    w_in_payload.data = w_in_payload.ctrl.illegal ? '0 : in_a;
  end

  assign w_stage_in[0] = w_in_payload;

  for (genvar s = 1; s < PIPE_STAGES; s++) begin : g_stage_link
    assign w_stage_in[s] = r_pipe[s-1];
  end

  for (genvar k = 0; k < SHAMT_W; k++) begin : g_level
    localparam int STG = level_stage(SHAMT_W, PIPE_STAGES, k);
    logic [XLEN-1:0] w_din;
    if (k == level_first(SHAMT_W, PIPE_STAGES, STG)) begin : g_head
      assign w_din = w_stage_in[STG].data;
    end else begin : g_chain
      assign w_din = w_lvl_out[k-1];
    end
    shift_level #(
      .XLEN  (XLEN),
      .AMOUNT(1 << k)
    ) u_level (
      .i_data (w_din),
      .i_en   (w_stage_in[STG].shamt[k]),
      .i_right(w_stage_in[STG].ctrl.right),
      .i_mode (w_stage_in[STG].ctrl.mode),
      .i_fill (w_stage_in[STG].ctrl.fill),
      .o_data (w_lvl_out[k])
    );
  end

  for (genvar s = 0; s < PIPE_STAGES; s++) begin : g_stage_out
    assign w_stage_data[s] = w_lvl_out[level_first(SHAMT_W, PIPE_STAGES, s + 1) - 1];
  end

  // High shift-amount bits are discarded; the output stage only exposes data, tag and illegal.
  assign w_unused_ok = ^{in_b[XLEN-1:SHAMT_W], r_pipe[PIPE_STAGES-1].shamt,
                         r_pipe[PIPE_STAGES-1].ctrl.right, r_pipe[PIPE_STAGES-1].ctrl.mode,
                         r_pipe[PIPE_STAGES-1].ctrl.fill};

  // Whole pipe moves in lockstep on advance; flush drops every valid bit regardless of stall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= '0;
      for (int s = 0; s < PIPE_STAGES; s++) r_pipe[s] <= '0;
    end else if (flush) begin
      r_valid <= '0;
    end else if (w_advance) begin
      r_valid[0] <= in_valid;
      for (int s = 1; s < PIPE_STAGES; s++) r_valid[s] <= r_valid[s-1];
      for (int s = 0; s < PIPE_STAGES; s++) begin
        r_pipe[s]      <= w_stage_in[s];
        r_pipe[s].data <= w_stage_data[s];
      end
    end
  end

endmodule

// File: tb/tb_pipelined_shifter.sv
// tb/tb_pipelined_shifter.sv - randomized and directed checks of pipelined_shifter against a queue model
module tb_pipelined_shifter;

  localparam int XLEN = 32;
  localparam int PS   = 2;
  localparam int TW   = 5;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            flush = 1'b0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [XLEN-1:0] in_a = '0;
  logic [XLEN-1:0] in_b = '0;
  logic [2:0]      in_op = '0;
  logic [TW-1:0]   in_tag = '0;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic [XLEN-1:0] out_res;
  logic [TW-1:0]   out_tag;
  logic            out_illegal;

  pipelined_shifter #(.XLEN(XLEN), .PIPE_STAGES(PS), .TAG_W(TW)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .in_op(in_op), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_res(out_res),
    .out_tag(out_tag), .out_illegal(out_illegal)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [XLEN-1:0] res;
    logic [TW-1:0]   tag;
    logic            ill;
  } exp_t;

  exp_t        q[$];
  int          n_checks = 0;
  int          n_fail = 0;
  logic        hold_prev = 1'b0;
  logic [38:0] hold_val = '0;
  logic        last_in_ready = 1'b0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic exp_t model_shift(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
    exp_t e;
    int   sh;
    sh    = int'(b % 32);
    e.ill = 1'b0;
    e.tag = '0;
    case (op)
      3'd0: e.res = a << sh;
      3'd1: e.res = a >> sh;
      3'd2: e.res = $unsigned($signed(a) >>> sh);
`ifdef SHIFTER_ROTATE_EN
      3'd3: e.res = (sh == 0) ? a : ((a << sh) | (a >> (32 - sh)));
      3'd4: e.res = (sh == 0) ? a : ((a >> sh) | (a << (32 - sh)));
`endif
      default: begin
        e.res = '0;
        e.ill = 1'b1;
      end
    endcase
    return e;
  endfunction

  // One cycle: drive at edge+1, score handshakes, advance to next edge+1.
  task automatic step(input logic v, input logic [31:0] a, input logic [31:0] b, input logic [2:0] op,
                      input logic [TW-1:0] tag, input logic ordy, input logic fl, output logic acc);
    exp_t e;
    in_valid = v; in_a = a; in_b = b; in_op = op; in_tag = tag; out_ready = ordy; flush = fl;
    #1;
    last_in_ready = in_ready;
    if (hold_prev) check("stall_stable", {out_valid, out_illegal, out_tag, out_res}, hold_val);
    hold_prev = out_valid && !ordy && !fl;
    hold_val  = {out_valid, out_illegal, out_tag, out_res};
    if (out_valid && ordy) begin
      check("out_expected", q.size() != 0, 1);
      if (q.size() != 0) begin
        e = q.pop_front();
        check("res", out_res, e.res);
        check("tag", out_tag, e.tag);
        check("illegal", out_illegal, e.ill);
      end
    end
    acc = v && in_ready && !fl;
    if (fl) q.delete();
    else if (acc) begin
      e = model_shift(a, b, op);
      e.tag = tag;
      q.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n, input logic ordy);
    logic acc;
    for (int i = 0; i < n; i++) step(1'b0, '0, '0, '0, '0, ordy, 1'b0, acc);
  endtask

  task automatic directed(input string name, input logic [31:0] a, input logic [31:0] b, input logic [2:0] op,
                          input logic [TW-1:0] tag, input logic [31:0] exp_res, input logic exp_ill);
    logic acc;
    int   lat;
    step(1'b1, a, b, op, tag, 1'b1, 1'b0, acc);
    check({name, "_accepted"}, acc, 1);
    lat = 0;
    for (int i = 0; i < 10; i++) begin
      lat++;
      if (out_valid) break;
      step(1'b0, '0, '0, '0, '0, 1'b1, 1'b0, acc);
    end
    check({name, "_latency"}, lat, PS);
    check({name, "_res"}, out_res, exp_res);
    check({name, "_illegal"}, out_illegal, exp_ill);
    step(1'b0, '0, '0, '0, '0, 1'b1, 1'b0, acc);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic acc;
    int   idx;
    logic [31:0] ba [8];
    logic [31:0] bb [8];
    logic [2:0]  bo [8];

    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_res", out_res, 0);
    check("rst_out_tag", out_tag, 0);
    check("rst_out_illegal", out_illegal, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    check("rst_in_ready", in_ready, 1);
    @(posedge clk);
    #1;

    directed("sra_sign", 32'h8000_0000, 32'd4, 3'b010, 5'd3, 32'hF800_0000, 1'b0);
    directed("sll_wrap_shamt", 32'h0000_0001, 32'd33, 3'b000, 5'd4, 32'h0000_0002, 1'b0);
    directed("srl_zero", 32'hFFFF_FFFF, 32'd0, 3'b001, 5'd5, 32'hFFFF_FFFF, 1'b0);
    directed("sll_31", 32'h0000_0003, 32'd31, 3'b000, 5'd6, 32'h8000_0000, 1'b0);
    directed("sra_pos_63", 32'h7FFF_FFFF, 32'd63, 3'b010, 5'd7, 32'h0000_0000, 1'b0);
    directed("op111", 32'h0000_1234, 32'd3, 3'b111, 5'd8, 32'h0000_0000, 1'b1);
`ifdef SHIFTER_ROTATE_EN
    directed("ror1", 32'h0000_0001, 32'd1, 3'b100, 5'd9, 32'h8000_0000, 1'b0);
    directed("rol4", 32'h8000_0001, 32'd4, 3'b011, 5'd10, 32'h0000_0018, 1'b0);
`else
    directed("ror1", 32'h0000_0001, 32'd1, 3'b100, 5'd9, 32'h0000_0000, 1'b1);
    directed("rol4", 32'h8000_0001, 32'd4, 3'b011, 5'd10, 32'h0000_0000, 1'b1);
`endif

    // Back-to-back eight ops with the consumer stalled in cycles 3..5.
    for (int i = 0; i < 8; i++) begin
      ba[i] = $urandom;
      bb[i] = $urandom;
      bo[i] = 3'($urandom_range(0, 2));
    end
    idx = 0;
    for (int c = 0; c < 40 && (idx < 8 || q.size() != 0); c++) begin
      logic ordy;
      ordy = !(c >= 3 && c <= 5);
      if (idx < 8) step(1'b1, ba[idx], bb[idx], bo[idx], 5'(idx + 16), ordy, 1'b0, acc);
      else step(1'b0, '0, '0, '0, '0, ordy, 1'b0, acc);
      if (c < 8) check("b2b_in_ready", last_in_ready, (c >= 3 && c <= 5) ? 0 : 1);
      if (acc) idx++;
    end
    check("b2b_all_accepted", idx, 8);
    check("b2b_drained", q.size(), 0);

    // Flush with two ops in flight; the op offered during flush is dropped.
    step(1'b1, 32'h0000_00F0, 32'd1, 3'b000, 5'd1, 1'b1, 1'b0, acc);
    step(1'b1, 32'h0000_00F0, 32'd2, 3'b001, 5'd2, 1'b1, 1'b0, acc);
    step(1'b1, 32'h0000_00F0, 32'd3, 3'b000, 5'd11, 1'b0, 1'b1, acc);
    check("flush_out_valid", out_valid, 0);
    directed("after_flush", 32'h0000_00F0, 32'd4, 3'b000, 5'd12, 32'h0000_0F00, 1'b0);
    idle(4, 1'b1);
    check("flush_drained", q.size(), 0);

    // Asynchronous reset while the output stage holds a result.
    step(1'b1, 32'hFFFF_0000, 32'd0, 3'b000, 5'd21, 1'b0, 1'b0, acc);
    step(1'b1, 32'h1234_5678, 32'd8, 3'b001, 5'd22, 1'b0, 1'b0, acc);
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_out_res", out_res, 0);
    check("midrst_out_tag", out_tag, 0);
    check("midrst_out_illegal", out_illegal, 0);
    check("midrst_in_ready", in_ready, 1);
    q.delete();
    hold_prev = 1'b0;
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 6; i++) begin
      check("post_reset_quiet", out_valid, 0);
      idle(1, 1'b1);
    end

    // Randomized traffic with backpressure and occasional flush.
    for (int c = 0; c < 400; c++) begin
      step(($urandom_range(0, 3) != 0), $urandom, $urandom, 3'($urandom_range(0, 7)), 5'($urandom),
           ($urandom_range(0, 3) != 0), ($urandom_range(0, 39) == 0), acc);
    end
    idle(10, 1'b1);
    check("random_drained", q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
